// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: shares one single-port, double-banked frame RAM
// between the PPU pixel writer (through a small write queue) and the VGA
// pixel reader (absolute priority, always from the front bank). Banks swap
// only at a VGA frame boundary once the PPU frame is complete and the queue
// has drained, so the display never shows a torn frame.
//
// Optional build macro: FB_DROP_CNT_EN adds a saturating 16-bit drop_cnt
// output counting cycles where the PPU writes while ppu_wr_full is high.
//
// Ports:
//   clock, rst_n               clock, synchronous active-low reset
//   ppu_wr/_addr/_data         PPU write request and payload
//   ppu_frame_end              PPU frame complete pulse
//   ppu_wr_full                queue cannot accept (registered)
//   vga_rd/_addr               VGA read request
//   vga_frame_end              VGA frame complete pulse
//   vga_rd_valid/_data         returned pixel, RD_LAT+2 cycles after request
//   ram_addr/_wr/_rd/_wdata    registered RAM command, ram_addr = {bank, addr}
//   ram_q                      RAM read data
//   front_bank                 bank currently displayed
//   swap_pending               PPU frame done, swap not yet taken
module frame_buffer_arbiter #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 6,
    parameter int unsigned WQ_DEPTH = 4,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              ppu_wr,
    input  logic [ADDR_W-1:0] ppu_wr_addr,
    input  logic [DATA_W-1:0] ppu_wr_data,
    input  logic              ppu_frame_end,
    output logic              ppu_wr_full,
    input  logic              vga_rd,
    input  logic [ADDR_W-1:0] vga_rd_addr,
    input  logic              vga_frame_end,
    output logic              vga_rd_valid,
    output logic [DATA_W-1:0] vga_rd_data,
    output logic [ADDR_W:0]   ram_addr,
    output logic              ram_wr,
    output logic              ram_rd,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_q,
    output logic              front_bank,
    output logic              swap_pending
`ifdef FB_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(WQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_READY = 2'd2
    } state_e;

    // Write queue storage and pointers
    logic [ADDR_W-1:0] wq_addr_q [WQ_DEPTH];
    logic [DATA_W-1:0] wq_data_q [WQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    state_e            state_q, state_d;
    logic              front_q, front_d;
    logic              swap_q, swap_d;
    logic              full_q, full_d;

    logic [ADDR_W:0]   ram_addr_q, ram_addr_d;
    logic              ram_wr_q, ram_wr_d;
    logic              ram_rd_q, ram_rd_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    logic [RD_LAT:0]   rd_pipe_q, rd_pipe_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              push_c;
    logic              pop_c;

    // Grant, queue bookkeeping, swap FSM and read-return tracking
    always_comb begin
        push_c      = ppu_wr && !full_q;
        pop_c       = !vga_rd && (count_q != '0);
        count_d     = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        wr_ptr_d    = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        state_d     = state_q;
        front_d     = front_q;
        case (state_q)
            ST_RUN: begin
                // A write accepted alongside the frame-end pulse is already in count_d
                if (ppu_frame_end) begin
                    state_d = (count_d == '0) ? ST_READY : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (count_d == '0) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (vga_frame_end) begin
                    state_d = ST_RUN;
                    front_d = ~front_q;
                end
            end
            default: state_d = ST_RUN;
        endcase
        swap_d      = (state_d != ST_RUN);
        full_d      = (count_d == CNT_W'(WQ_DEPTH)) || swap_d;

        // VGA reads win; reads in the swap cycle still see the old front bank
        ram_rd_d    = vga_rd;
        ram_wr_d    = pop_c;
        ram_addr_d  = '0;
        ram_wdata_d = '0;
        if (vga_rd) begin
            ram_addr_d  = {front_q, vga_rd_addr};
        end else if (pop_c) begin
            ram_addr_d  = {~front_q, wq_addr_q[rd_ptr_q]};
            ram_wdata_d = wq_data_q[rd_ptr_q];
        end

        // Stage RD_LAT lines up with ram_q being valid for that read
        rd_pipe_d   = {rd_pipe_q[RD_LAT-1:0], vga_rd};
        rd_valid_d  = rd_pipe_q[RD_LAT];
        rd_data_d   = rd_pipe_q[RD_LAT] ? ram_q : rd_data_q;
    end

    // Queue payload storage; contents need no reset, only the pointers do
    always_ff @(posedge clock) begin
        if (push_c) begin
            wq_addr_q[wr_ptr_q] <= ppu_wr_addr;
            wq_data_q[wr_ptr_q] <= ppu_wr_data;
        end
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_RUN;
            front_q     <= 1'b0;
            swap_q      <= 1'b0;
            full_q      <= 1'b0;
            ram_addr_q  <= '0;
            ram_wr_q    <= 1'b0;
            ram_rd_q    <= 1'b0;
            ram_wdata_q <= '0;
            rd_pipe_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            front_q     <= front_d;
            swap_q      <= swap_d;
            full_q      <= full_d;
            ram_addr_q  <= ram_addr_d;
            ram_wr_q    <= ram_wr_d;
            ram_rd_q    <= ram_rd_d;
            ram_wdata_q <= ram_wdata_d;
            rd_pipe_q   <= rd_pipe_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

`ifdef FB_DROP_CNT_EN
    logic [15:0] drop_q, drop_d;

    // Saturating count of writes refused while full
    always_comb begin
        drop_d = drop_q;
        if (ppu_wr && full_q && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`endif

    assign ppu_wr_full  = full_q;
    assign vga_rd_valid = rd_valid_q;
    assign vga_rd_data  = rd_data_q;
    assign ram_addr     = ram_addr_q;
    assign ram_wr       = ram_wr_q;
    assign ram_rd       = ram_rd_q;
    assign ram_wdata    = ram_wdata_q;
    assign front_bank   = front_q;
    assign swap_pending = swap_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Testbench for frame_buffer_arbiter: table-driven vectors for queueing and
// read priority, plus hand-written sequences for bank swap and reset corners.
// A behavioural RAM (one-cycle read latency) returns a fixed pattern for
// locations the DUT has not written.
module tb_frame_buffer_arbiter;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 6;

    logic              clock = 1'b0;
    logic              rst_n;
    logic              ppu_wr;
    logic [ADDR_W-1:0] ppu_wr_addr;
    logic [DATA_W-1:0] ppu_wr_data;
    logic              ppu_frame_end;
    logic              ppu_wr_full;
    logic              vga_rd;
    logic [ADDR_W-1:0] vga_rd_addr;
    logic              vga_frame_end;
    logic              vga_rd_valid;
    logic [DATA_W-1:0] vga_rd_data;
    logic [ADDR_W:0]   ram_addr;
    logic              ram_wr;
    logic              ram_rd;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_q;
    logic              front_bank;
    logic              swap_pending;
`ifdef FB_DROP_CNT_EN
    logic [15:0]       drop_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    frame_buffer_arbiter #(
        .ADDR_W(16), .DATA_W(6), .WQ_DEPTH(4), .RD_LAT(1)
    ) dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .ppu_wr        (ppu_wr),
        .ppu_wr_addr   (ppu_wr_addr),
        .ppu_wr_data   (ppu_wr_data),
        .ppu_frame_end (ppu_frame_end),
        .ppu_wr_full   (ppu_wr_full),
        .vga_rd        (vga_rd),
        .vga_rd_addr   (vga_rd_addr),
        .vga_frame_end (vga_frame_end),
        .vga_rd_valid  (vga_rd_valid),
        .vga_rd_data   (vga_rd_data),
        .ram_addr      (ram_addr),
        .ram_wr        (ram_wr),
        .ram_rd        (ram_rd),
        .ram_wdata     (ram_wdata),
        .ram_q         (ram_q),
        .front_bank    (front_bank),
`ifdef FB_DROP_CNT_EN
        .drop_cnt      (drop_cnt),
`endif
        .swap_pending  (swap_pending)
    );

    // Background content of untouched RAM locations
    function automatic logic [5:0] pat(input logic [16:0] a);
        return a[5:0] ^ {a[16], 5'h0B};
    endfunction

    // Behavioural RAM, read data valid the cycle after ram_rd
    logic [5:0] mem   [131072];
    bit         wrote [131072];
    always @(posedge clock) begin
        if (ram_wr) begin
            mem[ram_addr]   <= ram_wdata;
            wrote[ram_addr] <= 1'b1;
        end
        if (ram_rd) begin
            ram_q <= wrote[ram_addr] ? mem[ram_addr] : pat(ram_addr);
        end
    end

    typedef struct {
        logic        wr;
        logic [15:0] wa;
        logic [5:0]  wd;
        logic        rd;
        logic [15:0] ra;
        logic        e_wr;
        logic        e_rd;
        logic [16:0] e_addr;
        logic [5:0]  e_wd;
        logic        e_full;
        logic        e_val;
        logic [5:0]  e_dat;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [15:0] wa, input logic [5:0] wd,
                                input logic rd, input logic [15:0] ra,
                                input logic ewr, input logic erd, input logic [16:0] eaddr,
                                input logic [5:0] ewd, input logic efull,
                                input logic evl, input logic [5:0] edat);
        vec_t v;
        v.wr = wr; v.wa = wa; v.wd = wd; v.rd = rd; v.ra = ra;
        v.e_wr = ewr; v.e_rd = erd; v.e_addr = eaddr; v.e_wd = ewd;
        v.e_full = efull; v.e_val = evl; v.e_dat = edat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic wr, input logic [15:0] wa, input logic [5:0] wd,
                          input logic rd, input logic [15:0] ra,
                          input logic pfe, input logic vfe);
        ppu_wr        = wr;
        ppu_wr_addr   = wa;
        ppu_wr_data   = wd;
        vga_rd        = rd;
        vga_rd_addr   = ra;
        ppu_frame_end = pfe;
        vga_frame_end = vfe;
    endtask

    // Apply inputs for one cycle, then sample just after the edge
    task automatic cyc(input logic wr, input logic [15:0] wa, input logic [5:0] wd,
                       input logic rd, input logic [15:0] ra,
                       input logic pfe, input logic vfe);
        set_in(wr, wa, wd, rd, ra, pfe, vfe);
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 16'h0, 6'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ram_wr"}, 32'(ram_wr), 32'd0);
        chk({tag, " ram_rd"}, 32'(ram_rd), 32'd0);
        chk({tag, " ram_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, " full"}, 32'(ppu_wr_full), 32'd0);
        chk({tag, " valid"}, 32'(vga_rd_valid), 32'd0);
        chk({tag, " front"}, 32'(front_bank), 32'd0);
        chk({tag, " swap"}, 32'(swap_pending), 32'd0);
`ifdef FB_DROP_CNT_EN
        chk({tag, " drop_cnt"}, 32'(drop_cnt), 32'd0);
`endif
    endtask

    vec_t tbl [17];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Queue retirement, then reads holding off writes until full
        tbl[0]  = mk(1, 16'h0000, 6'h01, 0, 16'h0000, 0, 0, 17'h00000, 6'h00, 0, 0, 6'h00);
        tbl[1]  = mk(1, 16'h0001, 6'h02, 0, 16'h0000, 1, 0, 17'h10000, 6'h01, 0, 0, 6'h00);
        tbl[2]  = mk(1, 16'h0002, 6'h03, 0, 16'h0000, 1, 0, 17'h10001, 6'h02, 0, 0, 6'h00);
        tbl[3]  = mk(1, 16'h0003, 6'h04, 0, 16'h0000, 1, 0, 17'h10002, 6'h03, 0, 0, 6'h00);
        tbl[4]  = mk(0, 16'h0000, 6'h00, 0, 16'h0000, 1, 0, 17'h10003, 6'h04, 0, 0, 6'h00);
        tbl[5]  = mk(0, 16'h0000, 6'h00, 0, 16'h0000, 0, 0, 17'h00000, 6'h00, 0, 0, 6'h00);
        tbl[6]  = mk(1, 16'h0010, 6'h10, 1, 16'h0100, 0, 1, 17'h00100, 6'h00, 0, 0, 6'h00);
        tbl[7]  = mk(1, 16'h0011, 6'h11, 1, 16'h0101, 0, 1, 17'h00101, 6'h00, 0, 0, 6'h00);
        tbl[8]  = mk(1, 16'h0012, 6'h12, 1, 16'h0102, 0, 1, 17'h00102, 6'h00, 0, 1, pat(17'h00100));
        tbl[9]  = mk(1, 16'h0013, 6'h13, 1, 16'h0103, 0, 1, 17'h00103, 6'h00, 1, 1, pat(17'h00101));
        tbl[10] = mk(1, 16'h0014, 6'h14, 1, 16'h0104, 0, 1, 17'h00104, 6'h00, 1, 1, pat(17'h00102));
        tbl[11] = mk(1, 16'h0014, 6'h14, 1, 16'h0105, 0, 1, 17'h00105, 6'h00, 1, 1, pat(17'h00103));
        tbl[12] = mk(1, 16'h0014, 6'h14, 0, 16'h0000, 1, 0, 17'h10010, 6'h10, 0, 1, pat(17'h00104));
        tbl[13] = mk(0, 16'h0000, 6'h00, 0, 16'h0000, 1, 0, 17'h10011, 6'h11, 0, 1, pat(17'h00105));
        tbl[14] = mk(0, 16'h0000, 6'h00, 0, 16'h0000, 1, 0, 17'h10012, 6'h12, 0, 0, 6'h00);
        tbl[15] = mk(0, 16'h0000, 6'h00, 0, 16'h0000, 1, 0, 17'h10013, 6'h13, 0, 0, 6'h00);
        tbl[16] = mk(0, 16'h0000, 6'h00, 0, 16'h0000, 0, 0, 17'h00000, 6'h00, 0, 0, 6'h00);

        // Reset
        rst_n = 1'b0;
        set_in(1'b0, 16'h0, 6'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].rd, tbl[i].ra, 1'b0, 1'b0);
            chk($sformatf("v%0d ram_wr", i), 32'(ram_wr), 32'(tbl[i].e_wr));
            chk($sformatf("v%0d ram_rd", i), 32'(ram_rd), 32'(tbl[i].e_rd));
            chk($sformatf("v%0d full", i), 32'(ppu_wr_full), 32'(tbl[i].e_full));
            chk($sformatf("v%0d valid", i), 32'(vga_rd_valid), 32'(tbl[i].e_val));
            if (tbl[i].e_wr || tbl[i].e_rd)
                chk($sformatf("v%0d ram_addr", i), 32'(ram_addr), 32'(tbl[i].e_addr));
            if (tbl[i].e_wr)
                chk($sformatf("v%0d ram_wdata", i), 32'(ram_wdata), 32'(tbl[i].e_wd));
            if (tbl[i].e_val)
                chk($sformatf("v%0d rd_data", i), 32'(vga_rd_data), 32'(tbl[i].e_dat));
        end
`ifdef FB_DROP_CNT_EN
        chk("drop_cnt after full", 32'(drop_cnt), 32'd3);
`endif

        // Write accepted with frame end belongs to the ending frame, then swap
        cyc(1'b1, 16'h0005, 6'h2A, 1'b0, 16'h0, 1'b1, 1'b0);
        chk("fe+wr swap", 32'(swap_pending), 32'd1);
        chk("fe+wr full", 32'(ppu_wr_full), 32'd1);
        idle();
        chk("drain ram_wr", 32'(ram_wr), 32'd1);
        chk("drain ram_addr", 32'(ram_addr), 32'h10005);
        chk("drain ram_wdata", 32'(ram_wdata), 32'h2A);
        cyc(1'b0, 16'h0, 6'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("swap1 front", 32'(front_bank), 32'd1);
        chk("swap1 swap", 32'(swap_pending), 32'd0);
        chk("swap1 full", 32'(ppu_wr_full), 32'd0);
        cyc(1'b0, 16'h0, 6'h0, 1'b1, 16'h0005, 1'b0, 1'b0);
        chk("rd5 ram_addr", 32'(ram_addr), 32'h10005);
        idle();
        idle();
        chk("rd5 valid", 32'(vga_rd_valid), 32'd1);
        chk("rd5 data", 32'(vga_rd_data), 32'h2A);

        // Frame end with queued writes; early VGA frame end must not swap
        cyc(1'b1, 16'h0020, 6'h01, 1'b1, 16'h0200, 1'b0, 1'b0);
        cyc(1'b1, 16'h0021, 6'h02, 1'b1, 16'h0201, 1'b0, 1'b0);
        cyc(1'b1, 16'h0022, 6'h03, 1'b1, 16'h0202, 1'b0, 1'b0);
        chk("q3 full", 32'(ppu_wr_full), 32'd0);
        cyc(1'b0, 16'h0, 6'h0, 1'b1, 16'h0203, 1'b1, 1'b0);
        chk("drain swap", 32'(swap_pending), 32'd1);
        chk("drain full", 32'(ppu_wr_full), 32'd1);
        cyc(1'b0, 16'h0, 6'h0, 1'b1, 16'h0204, 1'b0, 1'b1);
        chk("early vfe front", 32'(front_bank), 32'd1);
        chk("early vfe swap", 32'(swap_pending), 32'd1);
        idle();
        chk("pop0 ram_wr", 32'(ram_wr), 32'd1);
        chk("pop0 ram_addr", 32'(ram_addr), 32'h00020);
        chk("pop0 ram_wdata", 32'(ram_wdata), 32'h01);
        chk("pop0 full", 32'(ppu_wr_full), 32'd1);
        chk("rd203 valid", 32'(vga_rd_valid), 32'd1);
        chk("rd203 data", 32'(vga_rd_data), 32'(pat(17'h10203)));
        idle();
        chk("pop1 ram_addr", 32'(ram_addr), 32'h00021);
        idle();
        chk("pop2 ram_addr", 32'(ram_addr), 32'h00022);
        chk("pop2 ram_wdata", 32'(ram_wdata), 32'h03);
        idle();
        chk("ready ram_wr", 32'(ram_wr), 32'd0);
        chk("ready swap", 32'(swap_pending), 32'd1);
        chk("ready full", 32'(ppu_wr_full), 32'd1);
        chk("ready front", 32'(front_bank), 32'd1);

        // Read in the swap cycle uses the old bank, the next one the new bank
        cyc(1'b0, 16'h0, 6'h0, 1'b1, 16'h0007, 1'b0, 1'b1);
        chk("swapcyc ram_rd", 32'(ram_rd), 32'd1);
        chk("swapcyc ram_addr", 32'(ram_addr), 32'h10007);
        chk("swap2 front", 32'(front_bank), 32'd0);
        chk("swap2 swap", 32'(swap_pending), 32'd0);
        chk("swap2 full", 32'(ppu_wr_full), 32'd0);
        cyc(1'b0, 16'h0, 6'h0, 1'b1, 16'h0007, 1'b0, 1'b0);
        chk("postswap ram_addr", 32'(ram_addr), 32'h00007);
        idle();
        chk("oldbank data", 32'(vga_rd_data), 32'(pat(17'h10007)));
        idle();
        chk("newbank valid", 32'(vga_rd_valid), 32'd1);
        chk("newbank data", 32'(vga_rd_data), 32'(pat(17'h00007)));

        // Empty-queue swap back to bank 1, then reset with a read in flight
        cyc(1'b0, 16'h0, 6'h0, 1'b0, 16'h0, 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 6'h0, 1'b0, 16'h0, 1'b0, 1'b1);
        chk("swap3 front", 32'(front_bank), 32'd1);
        cyc(1'b0, 16'h0, 6'h0, 1'b1, 16'h0300, 1'b0, 1'b0);
        chk("pre-rst ram_rd", 32'(ram_rd), 32'd1);
        rst_n = 1'b0;
        idle();
        chk_all_zero("midrst");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            chk($sformatf("postrst%0d valid", i), 32'(vga_rd_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
